seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed 7-segment scanner with a load/commit
// handshake. Each digit slot is REFRESH_DIV cycles long and starts with
// GAP_CYCLES of blanking to stop ghosting between digits. A new value is held
// in a shadow register and only reaches the display at a frame wrap, so a
// frame never shows a mix of old and new digits.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 is
// always shown).
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  output logic        ready,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic {GAP, DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp, shadow;
  logic          pending;
  logic          slot_end, wrap, accept;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          lz_blank;

  assign slot_end = en && (cnt == CW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx == 2'd3);
  assign ready    = ~pending;
  assign accept   = load && ~pending;
  assign nib      = disp[{idx, 2'b00} +: 4];

  // Slot counter and digit index; both freeze while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (en) begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GAP;
    else        state <= state_nxt;
  end

  // FSM next state: blank for the first GAP_CYCLES of a slot, then drive.
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        GAP:     if (cnt == CW'(GAP_CYCLES - 1))  state_nxt = DRIVE;
        DRIVE:   if (cnt == CW'(REFRESH_DIV - 1)) state_nxt = GAP;
        default: state_nxt = GAP;
      endcase
    end
  end

  // Handshake: capture into shadow when idle; commit to display only at a
  // frame wrap. A load taken on the wrap cycle sees pending=0 there, so it
  // naturally waits for the following wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp    <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
    end else if (wrap && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= value;
      pending <= 1'b1;
    end
  end

  // Hex to active-low segment decode.
  always_comb begin
    seg_dec = 7'b1111111;
    case (nib)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'b1111111;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above 0 is blanked when it and every higher nibble are zero.
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd1:    lz_blank = (disp[15:4]  == 12'h000);
      2'd2:    lz_blank = (disp[15:8]  == 8'h00);
      2'd3:    lz_blank = (disp[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  // All four digits are always driven.
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Registered outputs, one cycle behind state/counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode      <= 4'b1111;
      segment    <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en && state == DRIVE) begin
        anode   <= lz_blank ? 4'b1111 : ~(4'b0001 << idx);
        segment <= seg_dec;
      end else begin
        anode   <= 4'b1111;
        segment <= 7'b1111111;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at REFRESH_DIV=8, GAP_CYCLES=2. The reference model
// tracks a single enabled-cycle tick within the 32-cycle frame and derives
// digit, slot position and expected outputs arithmetically from it.
module tb_seg_scan_ctrl;
  localparam int DIV = 8;
  localparam int GAP = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        ready;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.REFRESH_DIV(DIV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .ready(ready), .anode(anode), .segment(segment), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state
  int          mtick = 0;
  logic [15:0] mdisp = 16'h0000;
  logic [15:0] mshadow = 16'h0000;
  logic        mpend = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_fd = 1'b0;

  function automatic logic [10:0] drive_out(int dig, logic [15:0] d);
    logic [15:0] hi;
    logic [3:0]  an;
    hi = d >> (4 * dig);
    an = 4'hF;
    an[dig] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (dig > 0 && hi == 16'h0000) an = 4'hF;
`endif
    return {an, SEG[hi[3:0]]};
  endfunction

  // Reference model: update on each clock, reset asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtick <= 0; mdisp <= 16'h0; mshadow <= 16'h0; mpend <= 1'b0;
      exp_an <= 4'hF; exp_seg <= 7'h7F; exp_fd <= 1'b0;
    end else begin
      if (en && (mtick % DIV) >= GAP)
        {exp_an, exp_seg} <= drive_out((mtick / DIV) % 4, mdisp);
      else begin
        exp_an <= 4'hF; exp_seg <= 7'h7F;
      end
      exp_fd <= en && (mtick == FRAME - 1);
      if (en && mtick == FRAME - 1 && mpend) begin
        mdisp <= mshadow; mpend <= 1'b0;
      end else if (load && !mpend) begin
        mshadow <= value; mpend <= 1'b1;
      end
      if (en) mtick <= (mtick + 1) % FRAME;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("anode", {28'd0, anode}, {28'd0, exp_an});
    chk("segment", {25'd0, segment}, {25'd0, exp_seg});
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    chk("ready", {31'd0, ready}, {31'd0, ~mpend});
  end

  // Wait (at a negedge) until the model tick equals t; outputs then show tick t-1.
  task automatic wait_tick(int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mtick != t && n < 200);
    if (mtick != t) begin
      errors++;
      $display("FAIL wait_tick: got tick %0d expected %0d", mtick, t);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_anode", {28'd0, anode}, 32'hF);
    chk("rst_segment", {25'd0, segment}, 32'h7F);
    chk("rst_fd", {31'd0, frame_done}, 32'h0);
    chk("rst_ready", {31'd0, ready}, 32'h1);
    rst_n = 1'b1; en = 1'b1;

    // Idle scanning of zeros
    wait_tick(2);  chk("gap_blank", {28'd0, anode}, 32'hF);
    wait_tick(3);  chk("d0_anode", {28'd0, anode}, 32'hE);
    chk("d0_seg", {25'd0, segment}, 32'h40);
    wait_tick(12); chk("d1_anode", {28'd0, anode}, 32'hD);
    wait_tick(28); chk("d3_anode", {28'd0, anode}, 32'h7);
    wait_tick(0);  chk("frame_pulse", {31'd0, frame_done}, 32'h1);

    // Load mid-frame, second load ignored, commit at wrap
    wait_tick(5);  load = 1'b1; value = 16'hA1C4;
    @(negedge clk); chk("ready_drop", {31'd0, ready}, 32'h0);
    value = 16'h1234;
    @(negedge clk); load = 1'b0;
    wait_tick(12); chk("old_d1", {25'd0, segment}, 32'h40);
    wait_tick(0);  chk("ready_back", {31'd0, ready}, 32'h1);
    wait_tick(4);  chk("new_d0", {25'd0, segment}, 32'b0011001);
    wait_tick(12); chk("new_d1", {25'd0, segment}, 32'b1000110);
    wait_tick(20); chk("new_d2", {25'd0, segment}, 32'b1111001);
    chk("new_d2_an", {28'd0, anode}, 32'hB);
    wait_tick(28); chk("new_d3", {25'd0, segment}, 32'b0001000);

    // Pause during digit 2, resume mid-slot
    wait_tick(21); en = 1'b0;
    repeat (10) @(negedge clk);
    chk("pause_blank", {28'd0, anode}, 32'hF);
    en = 1'b1;
    @(negedge clk);
    chk("resume_an", {28'd0, anode}, 32'hB);
    chk("resume_seg", {25'd0, segment}, 32'b1111001);

    // Reset with a load pending
    wait_tick(28); load = 1'b1; value = 16'h5555;
    @(negedge clk); load = 1'b0;
    chk("pend_ready", {31'd0, ready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {28'd0, anode}, 32'hF);
    chk("async_seg", {25'd0, segment}, 32'h7F);
    chk("async_ready", {31'd0, ready}, 32'h1);
    @(negedge clk); rst_n = 1'b1;
    wait_tick(4);  chk("post_rst_d0", {25'd0, segment}, 32'h40);
    wait_tick(0);  wait_tick(12);
    chk("discarded", {25'd0, segment}, 32'h40);

`ifdef LEADING_ZERO_BLANK_EN
    wait_tick(0); load = 1'b1; value = 16'h0040;
    @(negedge clk); load = 1'b0;
    wait_tick(0);
    wait_tick(4);  chk("lz_d0", {25'd0, segment}, 32'h40);
    wait_tick(12); chk("lz_d1", {25'd0, segment}, 32'b0011001);
    chk("lz_d1_an", {28'd0, anode}, 32'hD);
    wait_tick(20); chk("lz_d2_an", {28'd0, anode}, 32'hF);
    wait_tick(28); chk("lz_d3_an", {28'd0, anode}, 32'hF);
`endif

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      en    = ($urandom % 10) != 0;
      load  = ($urandom % 8) == 0;
      value = 16'($urandom);
      if (($urandom % 3) == 0) value = value & 16'h00FF;
      if (($urandom % 500) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
